// File: rtl/updn_pkg.sv
// Shared types and defaults for the up/down modulo counter.
package updn_pkg;

    // Default counter width when the instantiating code does not override it.
    localparam int unsigned UPDN_DEF_WIDTH = 4;

    // Operation selected for the coming edge, decoded from the controls each cycle.
    typedef enum logic [1:0] {
        UPDN_IDLE = 2'd0,
        UPDN_UP   = 2'd1,
        UPDN_DN   = 2'd2,
        UPDN_LOAD = 2'd3
    } updn_op_e;

endpackage : updn_pkg

// File: rtl/updn_limit_det.sv
// Limit detection for the up/down counter: flags when the count sits at MAX or at 0.
module updn_limit_det #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
    input  logic [WIDTH-1:0] cnt_i,
    output logic             at_max_o,
    output logic             at_zero_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // Pure equality compares; the top uses these before any increment/decrement.
    assign at_max_o  = (cnt_i == MAX_V);
    assign at_zero_o = (cnt_i == '0);

endmodule : updn_limit_det

// File: rtl/updn_mod_counter.sv
// WIDTH-bit modulo-(MAX+1) up/down counter with enable, synchronous load,
// terminal-count flag and registered wrap pulse.
// Optional feature macro UPDN_CNT_SAT_EN: adds input Sat; when Sat=1 the count
// holds at the limit instead of wrapping and Wrap pulses as a saturation hit.
// Handshake: none -- every control is sampled on every rising Clock edge; CNT and
// Wrap update on that same edge, TC is a combinational view of CNT and Up.
module updn_mod_counter
    import updn_pkg::*;
#(
    parameter int unsigned WIDTH   = UPDN_DEF_WIDTH,
    parameter int unsigned MAX     = (1 << WIDTH) - 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
`ifdef UPDN_CNT_SAT_EN
    input  logic             Sat,
`endif
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             Wrap,
    output updn_op_e         Op
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;
    logic             sat_w;
    updn_op_e         op_w;

`ifdef UPDN_CNT_SAT_EN
    assign sat_w = Sat;
`else
    assign sat_w = 1'b0;
`endif

    updn_limit_det #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_limit_det (
        .cnt_i     (cnt_q),
        .at_max_o  (at_max),
        .at_zero_o (at_zero)
    );

    // Decode the controls into one operation; Load outranks En, En outranks hold.
    always_comb begin
        op_w = UPDN_IDLE;
        if (Load) begin
            op_w = UPDN_LOAD;
        end else if (En) begin
            op_w = Up ? UPDN_UP : UPDN_DN;
        end
    end

    // Next count and wrap flag; limits are checked before stepping so MAX = 2**WIDTH-1 is safe.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        unique case (op_w)
            UPDN_LOAD: begin
                cnt_d = (LoadVal > MAX_V) ? MAX_V : LoadVal;
            end
            UPDN_UP: begin
                if (at_max) begin
                    wrap_d = 1'b1;
                    cnt_d  = sat_w ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end
            UPDN_DN: begin
                if (at_zero) begin
                    wrap_d = 1'b1;
                    cnt_d  = sat_w ? cnt_q : MAX_V;
                end else begin
                    cnt_d = cnt_q - ONE_V;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Count and wrap registers; reset forces RST_VAL and clears Wrap without a clock.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= RST_V;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign CNT  = cnt_q;
    assign Wrap = wrap_q;
    assign TC   = Up ? at_max : at_zero;
    assign Op   = op_w;

endmodule : updn_mod_counter

// File: tb/tb_updn_mod_counter.sv
// Self-checking bench for updn_mod_counter (WIDTH=4, MAX=9, RST_VAL=0).
module tb_updn_mod_counter;
    import updn_pkg::*;

    localparam int W   = 4;
    localparam int MAX = 9;

    // ---------------- clock / reset ----------------
    logic         Clock = 1'b0;
    logic         Reset;
    logic         En, Up, Load, Sat;
    logic [W-1:0] LoadVal;
    logic [W-1:0] CNT;
    logic         TC, Wrap;
    updn_op_e     Op;

    always #5 Clock = ~Clock;

    updn_mod_counter #(
        .WIDTH   (W),
        .MAX     (MAX),
        .RST_VAL (0)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .En      (En),
        .Up      (Up),
        .Load    (Load),
        .LoadVal (LoadVal),
`ifdef UPDN_CNT_SAT_EN
        .Sat     (Sat),
`endif
        .CNT     (CNT),
        .TC      (TC),
        .Wrap    (Wrap),
        .Op      (Op)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    int           m_cnt    = 0;   // reference count
    logic [W-1:0] exp_q[$];       // expected counts, one per clocked step

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit sat_active();
`ifdef UPDN_CNT_SAT_EN
        return Sat;
`else
        return 1'b0;
`endif
    endfunction

    // Reference rules in plain modular arithmetic over the range 0..MAX.
    task automatic model_step(output int nxt, output int wrp);
        wrp = 0;
        nxt = m_cnt;
        if (Load) begin
            nxt = (int'(LoadVal) > MAX) ? MAX : int'(LoadVal);
        end else if (En && Up) begin
            wrp = (m_cnt == MAX);
            nxt = (wrp && sat_active()) ? m_cnt : (m_cnt + 1) % (MAX + 1);
        end else if (En) begin
            wrp = (m_cnt == 0);
            nxt = (wrp && sat_active()) ? m_cnt : (m_cnt + MAX) % (MAX + 1);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input string tag);
        int nxt, wrp;
        model_step(nxt, wrp);
        exp_q.push_back(W'(nxt));
        @(posedge Clock);
        #1;
        m_cnt = nxt;
        check({tag, "_cnt"}, int'(CNT), int'(exp_q.pop_front()));
        check({tag, "_wrap"}, int'(Wrap), wrp);
        check({tag, "_tc"}, int'(TC), Up ? int'(m_cnt == MAX) : int'(m_cnt == 0));
    endtask

    task automatic set_ctl(input logic en, input logic up, input logic ld, input int lv);
        En = en; Up = up; Load = ld; LoadVal = W'(lv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b0; Sat = 1'b0;
        set_ctl(0, 1, 0, 0);
        #2;
        check("reset_cnt", int'(CNT), 0);
        check("reset_wrap", int'(Wrap), 0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        m_cnt = 0;

        // Count to 6, then assert reset between edges.
        set_ctl(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) tick("pre_rst");
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_cnt", int'(CNT), 0);
        check("async_rst_wrap", int'(Wrap), 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            check("rst_hold_cnt", int'(CNT), 0);
        end
        Reset = 1'b1;
        m_cnt = 0;

        // Up 11 edges from 0: 1..9, 0, 1.
        set_ctl(1, 1, 0, 0);
        for (int i = 0; i < 11; i++) tick("up_run");

        // Back to 0 via load, then down: 9, 8, 7.
        set_ctl(0, 0, 1, 0);
        tick("load0");
        set_ctl(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("dn_run");

        // Load clamp, plain load, hold.
        set_ctl(1, 1, 1, 12);
        tick("load_clamp");
        check("load_clamp_val", int'(CNT), 9);
        set_ctl(1, 0, 1, 5);
        tick("load5");
        set_ctl(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_val", int'(CNT), 5);

        // Alternate direction from 0, then down-wrap at 0.
        set_ctl(0, 0, 1, 0);
        tick("load0b");
        for (int i = 0; i < 4; i++) begin
            set_ctl(1, (i % 2) == 0, 0, 0);
            tick("alt");
        end
        set_ctl(1, 0, 0, 0);
        tick("alt_dnwrap");
        check("alt_dnwrap_val", int'(CNT), 9);

`ifdef UPDN_CNT_SAT_EN
        // Saturation at both limits, then wrapping again with Sat=0.
        Sat = 1'b1;
        set_ctl(0, 1, 1, 8);
        tick("sat_ld8");
        set_ctl(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick("sat_up");
        set_ctl(0, 0, 1, 1);
        tick("sat_ld1");
        set_ctl(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick("sat_dn");
        Sat = 1'b0;
        set_ctl(1, 1, 0, 0);
        for (int i = 0; i < 11; i++) tick("nosat_up");
`endif

        // Random traffic, occasional load of any 4-bit value.
        for (int i = 0; i < 300; i++) begin
            set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 15));
            Sat = $urandom_range(0, 1) == 1;
            tick("rand");
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_updn_mod_counter
